// File: rtl/timer_share_pkg.sv
// Shared types and defaults for the shared interval timer.
// Imported by the arbiter and its slot counter.
package timer_share_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int CNT_W_DEF = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/timer_share_arbiter_slot_counter.sv
// The single up-counter shared by all requesters.
// Clear wins over enable; both resets give zero.
module slot_counter
  import timer_share_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] out
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out = cnt_q;

endmodule

// File: rtl/timer_share_arbiter.sv
// Round-robin owner of one interval timer shared by N_REQ requesters.
// Holds the FSM, round-robin pointer, target and winner select.
module timer_share_arbiter
  import timer_share_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] len,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       cnt_val
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e             state_q;
  logic [PTR_W-1:0]   rr_ptr_q;
  logic [CNT_W-1:0]   target_q;
  logic [N_REQ-1:0]   gnt_q;
  logic               done_q;

  logic               win_vld;
  logic [PTR_W-1:0]   win_idx;
  logic               own_req;
  logic               at_target;
  logic               cnt_clr;
  logic               cnt_en;
  logic [CNT_W-1:0]   cnt;

  // Search upward from rr_ptr+1; the lowest offset found wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[(int'(rr_ptr_q) + k) % N_REQ]) begin
        win_vld = 1'b1;
        win_idx = PTR_W'((int'(rr_ptr_q) + k) % N_REQ);
      end
    end
  end

  assign own_req   = req[rr_ptr_q];
  assign at_target = (cnt == target_q);
  assign cnt_clr   = (state_q != RUN) || !own_req;
  assign cnt_en    = (state_q == RUN) && !at_target;

  slot_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .en (cnt_en),
    .out(cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= PTR_W'(N_REQ - 1);
      target_q <= '0;
      gnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (win_vld) begin
            state_q  <= RUN;
            rr_ptr_q <= win_idx;
            target_q <= len[int'(win_idx)*CNT_W +: CNT_W];
            gnt_q    <= N_REQ'(1) << win_idx;
          end
        end
        RUN: begin
          // A dropped request beats completion: no done pulse.
          if (!own_req) begin
            state_q <= IDLE;
            gnt_q   <= '0;
          end else if (at_target) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign cnt_val = cnt;

endmodule

// File: tb/tb_timer_share_arbiter.sv
// Directed bench for the shared interval timer arbiter.
// Cycle tables plus hand sequences for multi-cycle corners.
module tb_timer_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [19:0] len;
  logic [3:0]  gnt;
  logic        busy;
  logic        done;
  logic [4:0]  cnt_val;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  timer_share_arbiter #(
    .N_REQ(4),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .len(len),
    .gnt(gnt),
    .busy(busy),
    .done(done),
    .cnt_val(cnt_val)
  );

  typedef struct {
    bit          rst;
    logic [3:0]  req;
    logic [19:0] len;
    logic [3:0]  gnt;
    bit          busy;
    bit          done;
    logic [4:0]  cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(bit r, logic [3:0] q, logic [19:0] l,
                              logic [3:0] g, bit b, bit d, logic [4:0] c);
    vec_t v;
    v.rst = r; v.req = q; v.len = l;
    v.gnt = g; v.busy = b; v.done = d; v.cnt = c;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(string nm, logic [3:0] g, bit b, bit d,
                         logic [4:0] c);
    chk({nm, " gnt"}, 32'(gnt), 32'(g));
    chk({nm, " busy"}, 32'(busy), 32'(b));
    chk({nm, " done"}, 32'(done), 32'(d));
    chk({nm, " cnt"}, 32'(cnt_val), 32'(c));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    rst = 1'b0;
  endtask

  localparam logic [19:0] ALL1 = {5'd1, 5'd1, 5'd1, 5'd1};

  initial begin
    rst = 1'b1;
    req = '0;
    len = '0;

    // Single request, len0=3
    vq.push_back(mk(1, 4'b0000, 20'd3, 4'b0000, 0, 0, 5'd0));
    vq.push_back(mk(0, 4'b0001, 20'd3, 4'b0001, 1, 0, 5'd0));
    vq.push_back(mk(0, 4'b0001, 20'd3, 4'b0001, 1, 0, 5'd1));
    vq.push_back(mk(0, 4'b0001, 20'd3, 4'b0001, 1, 0, 5'd2));
    vq.push_back(mk(0, 4'b0001, 20'd3, 4'b0001, 1, 0, 5'd3));
    vq.push_back(mk(0, 4'b0001, 20'd3, 4'b0001, 1, 1, 5'd3));
    vq.push_back(mk(0, 4'b0000, 20'd3, 4'b0000, 0, 0, 5'd0));
    vq.push_back(mk(0, 4'b0000, 20'd3, 4'b0000, 0, 0, 5'd0));
    // Round robin, all requesters, all lengths 1
    vq.push_back(mk(1, 4'b1111, ALL1, 4'b0000, 0, 0, 5'd0));
    for (int g = 0; g < 5; g++) begin
      logic [3:0] oh;
      oh = 4'b0001 << (g % 4);
      vq.push_back(mk(0, 4'b1111, ALL1, oh, 1, 0, 5'd0));
      vq.push_back(mk(0, 4'b1111, ALL1, oh, 1, 0, 5'd1));
      vq.push_back(mk(0, 4'b1111, ALL1, oh, 1, 1, 5'd1));
      vq.push_back(mk(0, 4'b1111, ALL1, 4'b0000, 0, 0, 5'd0));
    end

    foreach (vq[i]) begin
      rst = vq[i].rst;
      req = vq[i].req;
      len = vq[i].len;
      step();
      chk_all($sformatf("vec%0d", i), vq[i].gnt, vq[i].busy,
              vq[i].done, vq[i].cnt);
    end

    // len2 = 0
    do_reset();
    req = 4'b0100;
    len = 20'd0;
    step();
    chk_all("len0 grant", 4'b0100, 1, 0, 5'd0);
    step();
    chk_all("len0 done", 4'b0100, 1, 1, 5'd0);
    req = '0;
    step();
    chk_all("len0 idle", 4'b0000, 0, 0, 5'd0);

    // len2 = 31, no wrap
    do_reset();
    req = 4'b0100;
    len = {5'd0, 5'd31, 5'd0, 5'd0};
    step();
    chk_all("len31 grant", 4'b0100, 1, 0, 5'd0);
    for (int i = 1; i <= 31; i++) begin
      step();
      chk_all($sformatf("len31 c%0d", i), 4'b0100, 1, 0, 5'(i));
    end
    step();
    chk_all("len31 done", 4'b0100, 1, 1, 5'd31);
    req = '0;
    step();
    chk_all("len31 idle", 4'b0000, 0, 0, 5'd0);

    // Abort at cnt_val=4
    do_reset();
    req = 4'b0001;
    len = 20'd10;
    step();
    for (int i = 1; i <= 4; i++) step();
    chk_all("abort pre", 4'b0001, 1, 0, 5'd4);
    req = '0;
    step();
    chk_all("abort", 4'b0000, 0, 0, 5'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("abort nodone%0d", i), 32'(done), 32'd0);
    end

    // Reset mid-run at cnt_val=7
    do_reset();
    req = 4'b0010;
    len = {5'd0, 5'd0, 5'd20, 5'd0};
    step();
    for (int i = 1; i <= 7; i++) step();
    chk_all("rstmid pre", 4'b0010, 1, 0, 5'd7);
    rst = 1'b1;
    step();
    chk_all("rstmid", 4'b0000, 0, 0, 5'd0);
    rst = 1'b0;
    req = 4'b1001;
    len = {5'd2, 5'd0, 5'd0, 5'd2};
    step();
    chk_all("rstmid rr", 4'b0001, 1, 0, 5'd0);

    // len change after grant ignored
    do_reset();
    req = 4'b0010;
    len = {5'd0, 5'd0, 5'd5, 5'd0};
    step();
    chk_all("lenchg grant", 4'b0010, 1, 0, 5'd0);
    len = {5'd0, 5'd0, 5'd20, 5'd0};
    for (int i = 1; i <= 5; i++) begin
      step();
      chk_all($sformatf("lenchg c%0d", i), 4'b0010, 1, 0, 5'(i));
    end
    step();
    chk_all("lenchg done", 4'b0010, 1, 1, 5'd5);
    req = '0;
    step();
    chk_all("lenchg idle", 4'b0000, 0, 0, 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
